ccip_host_mem_model: RTL and testbench
======================================

Name: ccip_host_mem_model

Overview:
- FIU/host-side counterpart of the AFU's flattened CCI-P interface. It consumes c0Tx read requests and c1Tx write requests, and backs them with an internal line-addressed memory.
- It returns c0Rx read responses and c1Rx write responses, and drives c0TxAlmFull/c1TxAlmFull from queue occupancy.
- Used in simulation benches and FPGA loopback builds in place of the real FIU, so AFUs run closed-loop.

Parameters:
- MEM_ADDR_WIDTH, 10, memory depth in cache lines (2^N x 512 bits)
- RD_LATENCY, 8, minimum cycles from read-request acceptance to response (>=2)
- RQ_DEPTH, 16, read-request queue entries (power of 2)
- WQ_DEPTH, 16, write-response queue entries (power of 2)
- ALMFULL_THRESH, 12, occupancy at which AlmFull asserts (< depth)

Ports:
- pClk  in  1  clock
- pck_cp2af_softReset  in  1  reset, asynchronous, active-high
- c0Tx_hdr  in  CCIP_C0TX_HDR_WIDTH  read request header (t_ccip_c0_ReqMemHdr layout)
- c0Tx_valid  in  1  read request valid
- c1Tx_hdr  in  CCIP_C1TX_HDR_WIDTH  write request header (t_ccip_c1_ReqMemHdr layout)
- c1Tx_data  in  CCIP_CLDATA_WIDTH  write data
- c1Tx_valid  in  1  write request valid
- c0TxAlmFull  out  1  read queue almost full
- c1TxAlmFull  out  1  write-response queue almost full
- c0Rx_hdr  out  CCIP_C0RX_HDR_WIDTH  read response header
- c0Rx_data  out  CCIP_CLDATA_WIDTH  read data
- c0Rx_rspValid  out  1  read response valid
- c0Rx_mmioRdValid  out  1  constant 0
- c0Rx_mmioWrValid  out  1  constant 0
- c1Rx_hdr  out  CCIP_C1RX_HDR_WIDTH  write response header
- c1Rx_rspValid  out  1  write response valid
- err_status  out  3  sticky flags: [0] queue overflow, [1] address out of range, [2] cl_len != 0

Behaviour:
- Reset (async assert, sync deassert on pClk):
  - All outputs are 0 and both queues are empty.
  - Memory contents are not cleared; a reset mid-operation discards all in-flight requests with no responses.
- Read accept: c0Tx_valid sampled at edge t pushes {address[MEM_ADDR_WIDTH-1:0], mdata, t+RD_LATENCY} into the read queue.
- Read response:
  - When the head entry's due cycle is reached, register c0Rx_rspValid=1 with mem[address] in c0Rx_data.
  - Header fields: resp_type=eRSP_RDLINE, mdata echoed, cl_num=0, hit_miss=0, vc_used=eVC_VL0.
  - Latency is exactly RD_LATENCY when the queue has no backlog.
  - Responses are in order, at most one per cycle; a backlog delays responses but never reorders them.
- Write accept: c1Tx_valid at edge t writes c1Tx_data to mem[address] at that edge and pushes mdata into the write-response queue.
- Write response: the head is emitted one per cycle, earliest at cycle t+1. Header fields: resp_type=eRSP_WRLINE, mdata echoed, format=0, cl_num=0.
- Ordering rules:
  - A read whose response launches in the same cycle a write to the same line is accepted returns the old data.
  - A write accepted at any earlier edge is visible to the read.
- AlmFull: c0TxAlmFull = (read-queue count >= ALMFULL_THRESH), and likewise for c1TxAlmFull; both are registered.
- Overflow: a request arriving while its queue is full is dropped, err_status[0] sets, and no response is generated. A write is still applied to memory; only its response is lost.
- Address bits above MEM_ADDR_WIDTH nonzero: the access uses the low bits (wraps) and err_status[1] sets.
- cl_len != 0: served as a single line and err_status[2] sets.
- Simultaneous push and pop on the same queue in one cycle keeps the count unchanged; this is legal when full (pop frees the slot).
- err_status bits clear only on reset.

Decomposition:
- Package ccip_host_mem_model_pkg:
  - entry typedefs t_rd_entry {addr, mdata, due} and t_wr_entry {mdata}.
  - the due-counter width constant.
  - response-header build functions using the ccip_if_pkg enums.
- Sub-module ccip_host_req_fifo: parameterized synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty/count, instantiated twice.
- Due-time tracking uses a free-running cycle counter with wrap-safe comparison (counter width > log2(RD_LATENCY+RQ_DEPTH)+1).

Test Plan:
- Write addr 0x5, data 0xA5 repeated, mdata 0x11 at cycle 10 -> c1Rx_rspValid at cycle 11 with mdata 0x11. Then read addr 0x5, mdata 0x22 at cycle 20 -> c0Rx_rspValid at cycle 28, data 0xA5 repeated, mdata 0x22.
- 16 back-to-back reads, mdata 0..15 -> c0TxAlmFull high after the 12th accept; responses mdata 0..15 in order on 16 consecutive cycles starting at the first due cycle.
- A 17th read while 16 are outstanding -> dropped, err_status=3'b001, exactly 16 responses.
- Read addr 0x405 with MEM_ADDR_WIDTH=10 -> returns mem[0x005], err_status[1]=1. A write with cl_len=1 -> single-line response, err_status[2]=1.
- Assert reset with 4 reads outstanding -> all outputs 0 immediately (asynchronously). After release, no stale responses appear and a fresh read returns after exactly RD_LATENCY cycles.

Source files
------------

// File: rtl/ccip_host_mem_model_pkg.sv
// Shared types for the CCI-P host memory model: CCI-P header layouts, response enums,
// queue entry types and response-header builders.
package ccip_host_mem_model_pkg;

  localparam int CCIP_CLADDR_WIDTH   = 42;
  localparam int CCIP_MDATA_WIDTH    = 16;
  localparam int CCIP_CLDATA_WIDTH   = 512;
  localparam int CCIP_C0TX_HDR_WIDTH = 74;
  localparam int CCIP_C1TX_HDR_WIDTH = 80;
  localparam int CCIP_C0RX_HDR_WIDTH = 28;
  localparam int CCIP_C1RX_HDR_WIDTH = 28;

  // Cycle-stamp width; must stay comfortably wider than log2(RD_LATENCY+RQ_DEPTH)+1.
  localparam int DUE_W = 16;

  typedef enum logic [1:0] {
    eVC_VA  = 2'h0,
    eVC_VL0 = 2'h1,
    eVC_VH0 = 2'h2,
    eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4
  } t_ccip_c1_rsp;

  typedef struct packed {
    logic [1:0]                   vc_sel;
    logic [1:0]                   rsvd1;
    logic [1:0]                   cl_len;
    logic [3:0]                   req_type;
    logic [5:0]                   rsvd0;
    logic [CCIP_CLADDR_WIDTH-1:0] address;
    logic [CCIP_MDATA_WIDTH-1:0]  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    logic [5:0]                   rsvd2;
    logic [1:0]                   vc_sel;
    logic                         sop;
    logic                         rsvd1;
    logic [1:0]                   cl_len;
    logic [3:0]                   req_type;
    logic [5:0]                   rsvd0;
    logic [CCIP_CLADDR_WIDTH-1:0] address;
    logic [CCIP_MDATA_WIDTH-1:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc                    vc_used;
    logic                        rsvd1;
    logic                        hit_miss;
    logic [1:0]                  rsvd0;
    logic [1:0]                  cl_num;
    t_ccip_c0_rsp                resp_type;
    logic [CCIP_MDATA_WIDTH-1:0] mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_vc                    vc_used;
    logic                        rsvd1;
    logic                        hit_miss;
    logic                        format;
    logic                        rsvd0;
    logic [1:0]                  cl_num;
    t_ccip_c1_rsp                resp_type;
    logic [CCIP_MDATA_WIDTH-1:0] mdata;
  } t_ccip_c1_RspMemHdr;

  typedef struct packed {
    logic [CCIP_CLADDR_WIDTH-1:0] addr;
    logic [CCIP_MDATA_WIDTH-1:0]  mdata;
    logic [DUE_W-1:0]             due;
  } t_rd_entry;

  typedef struct packed {
    logic [CCIP_MDATA_WIDTH-1:0] mdata;
  } t_wr_entry;

  function automatic t_ccip_c0_RspMemHdr build_c0_rsp(input logic [CCIP_MDATA_WIDTH-1:0] mdata);
    t_ccip_c0_RspMemHdr h;
    h.vc_used   = eVC_VL0;
    h.rsvd1     = 1'b0;
    h.hit_miss  = 1'b0;
    h.rsvd0     = 2'b00;
    h.cl_num    = 2'b00;
    h.resp_type = eRSP_RDLINE;
    h.mdata     = mdata;
    return h;
  endfunction

  function automatic t_ccip_c1_RspMemHdr build_c1_rsp(input logic [CCIP_MDATA_WIDTH-1:0] mdata);
    t_ccip_c1_RspMemHdr h;
    h.vc_used   = eVC_VA;
    h.rsvd1     = 1'b0;
    h.hit_miss  = 1'b0;
    h.format    = 1'b0;
    h.rsvd0     = 1'b0;
    h.cl_num    = 2'b00;
    h.resp_type = eRSP_WRLINE;
    h.mdata     = mdata;
    return h;
  endfunction

endpackage

// File: rtl/ccip_host_mem_model_if.sv
// Flattened CCI-P channel bundle between an AFU (master) and the host model (slave).
interface ccip_host_mem_model_if;
  import ccip_host_mem_model_pkg::*;

  // Valid-only handshake: a *_valid / *_rspValid high at a rising edge is a transfer;
  // there is no ready. The AFU must stop issuing while the matching AlmFull is high.
  logic [CCIP_C0TX_HDR_WIDTH-1:0] c0Tx_hdr;
  logic                           c0Tx_valid;
  logic [CCIP_C1TX_HDR_WIDTH-1:0] c1Tx_hdr;
  logic [CCIP_CLDATA_WIDTH-1:0]   c1Tx_data;
  logic                           c1Tx_valid;
  logic                           c0TxAlmFull;
  logic                           c1TxAlmFull;
  logic [CCIP_C0RX_HDR_WIDTH-1:0] c0Rx_hdr;
  logic [CCIP_CLDATA_WIDTH-1:0]   c0Rx_data;
  logic                           c0Rx_rspValid;
  logic                           c0Rx_mmioRdValid;
  logic                           c0Rx_mmioWrValid;
  logic [CCIP_C1RX_HDR_WIDTH-1:0] c1Rx_hdr;
  logic                           c1Rx_rspValid;

  modport master (
    output c0Tx_hdr, c0Tx_valid, c1Tx_hdr, c1Tx_data, c1Tx_valid,
    input  c0TxAlmFull, c1TxAlmFull, c0Rx_hdr, c0Rx_data, c0Rx_rspValid,
           c0Rx_mmioRdValid, c0Rx_mmioWrValid, c1Rx_hdr, c1Rx_rspValid
  );

  modport slave (
    input  c0Tx_hdr, c0Tx_valid, c1Tx_hdr, c1Tx_data, c1Tx_valid,
    output c0TxAlmFull, c1TxAlmFull, c0Rx_hdr, c0Rx_data, c0Rx_rspValid,
           c0Rx_mmioRdValid, c0Rx_mmioWrValid, c1Rx_hdr, c1Rx_rspValid
  );

endinterface

// File: rtl/ccip_host_req_fifo.sv
// Synchronous FIFO with occupancy count; push while full is honoured only together with a pop.
module ccip_host_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = store_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // When full, wr_ptr equals rd_ptr; the head is read out before this edge overwrites it.
  always_ff @(posedge clk) begin
    if (do_push) store_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ccip_host_mem_model.sv
// Host-side CCI-P memory model: serves c0 reads after a fixed latency and c1 writes with
// next-cycle acknowledgements, backed by a line-addressed memory.
module ccip_host_mem_model
  import ccip_host_mem_model_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int RD_LATENCY     = 8,
  parameter int RQ_DEPTH       = 16,
  parameter int WQ_DEPTH       = 16,
  parameter int ALMFULL_THRESH = 12
) (
  input  logic                  pClk,
  input  logic                  pck_cp2af_softReset,
  ccip_host_mem_model_if.slave  ccip,
  output logic [2:0]            err_status
);
  localparam int RQ_CW = $clog2(RQ_DEPTH) + 1;
  localparam int WQ_CW = $clog2(WQ_DEPTH) + 1;
  localparam int RD_EW = $bits(t_rd_entry);
  localparam int WR_EW = $bits(t_wr_entry);

  t_ccip_c0_ReqMemHdr        c0_req;
  t_ccip_c1_ReqMemHdr        c1_req;
  logic [MEM_ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic                      rd_oor, wr_oor;

  assign c0_req  = t_ccip_c0_ReqMemHdr'(ccip.c0Tx_hdr);
  assign c1_req  = t_ccip_c1_ReqMemHdr'(ccip.c1Tx_hdr);
  assign rd_addr = c0_req.address[MEM_ADDR_WIDTH-1:0];
  assign wr_addr = c1_req.address[MEM_ADDR_WIDTH-1:0];
  assign rd_oor  = |c0_req.address[CCIP_CLADDR_WIDTH-1:MEM_ADDR_WIDTH];
  assign wr_oor  = |c1_req.address[CCIP_CLADDR_WIDTH-1:MEM_ADDR_WIDTH];

  logic [DUE_W-1:0] cyc_q;
  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) cyc_q <= '0;
    else                     cyc_q <= cyc_q + DUE_W'(1);
  end

  // ---------------- read path ----------------
  t_rd_entry        rq_in, rq_head;
  logic [RD_EW-1:0] rq_head_bits;
  logic             rq_push, rq_pop, rq_full, rq_empty;
  logic [RQ_CW-1:0] rq_count, rq_cnt_d;
  logic [DUE_W-1:0] due_diff;

  assign rq_in    = '{addr:  CCIP_CLADDR_WIDTH'(rd_addr),
                      mdata: c0_req.mdata,
                      due:   cyc_q + DUE_W'(RD_LATENCY)};
  assign rq_head  = t_rd_entry'(rq_head_bits);
  // Wrap-safe "now >= due": the difference is non-negative as a signed value.
  assign due_diff = cyc_q - rq_head.due;
  assign rq_pop   = !rq_empty && !due_diff[DUE_W-1];
  assign rq_push  = ccip.c0Tx_valid && (!rq_full || rq_pop);
  assign rq_cnt_d = rq_count + RQ_CW'(rq_push) - RQ_CW'(rq_pop);

  ccip_host_req_fifo #(.WIDTH(RD_EW), .DEPTH(RQ_DEPTH)) u_rd_q (
    .clk     (pClk),
    .rst     (pck_cp2af_softReset),
    .push_i  (rq_push),
    .data_i  (rq_in),
    .pop_i   (rq_pop),
    .data_o  (rq_head_bits),
    .full_o  (rq_full),
    .empty_o (rq_empty),
    .count_o (rq_count)
  );

  // ---------------- write path ----------------
  t_wr_entry        wq_in, wq_head;
  logic [WR_EW-1:0] wq_head_bits;
  logic             wq_push, wq_pop, wq_full, wq_empty;
  logic [WQ_CW-1:0] wq_count, wq_cnt_d;

  assign wq_in    = '{mdata: c1_req.mdata};
  assign wq_head  = t_wr_entry'(wq_head_bits);
  assign wq_pop   = !wq_empty;
  assign wq_push  = ccip.c1Tx_valid && (!wq_full || wq_pop);
  assign wq_cnt_d = wq_count + WQ_CW'(wq_push) - WQ_CW'(wq_pop);

  ccip_host_req_fifo #(.WIDTH(WR_EW), .DEPTH(WQ_DEPTH)) u_wr_q (
    .clk     (pClk),
    .rst     (pck_cp2af_softReset),
    .push_i  (wq_push),
    .data_i  (wq_in),
    .pop_i   (wq_pop),
    .data_o  (wq_head_bits),
    .full_o  (wq_full),
    .empty_o (wq_empty),
    .count_o (wq_count)
  );

  // Contents survive reset; a write lands even when its acknowledgement is dropped.
  logic [CCIP_CLDATA_WIDTH-1:0] mem [2**MEM_ADDR_WIDTH];
  always_ff @(posedge pClk) begin
    if (ccip.c1Tx_valid && !pck_cp2af_softReset) mem[wr_addr] <= ccip.c1Tx_data;
  end

  // ---------------- response / status registers ----------------
  logic                           c0_vld_q, c0_vld_d, c1_vld_q, c1_vld_d;
  logic [CCIP_C0RX_HDR_WIDTH-1:0] c0_hdr_q, c0_hdr_d;
  logic [CCIP_C1RX_HDR_WIDTH-1:0] c1_hdr_q, c1_hdr_d;
  logic [CCIP_CLDATA_WIDTH-1:0]   c0_data_q, c0_data_d;
  logic                           c0_af_q, c0_af_d, c1_af_q, c1_af_d;
  logic [2:0]                     err_q, err_d;
  logic                           ovf_err, oor_err, len_err;

  assign ovf_err = (ccip.c0Tx_valid && !rq_push) || (ccip.c1Tx_valid && !wq_push);
  assign oor_err = (ccip.c0Tx_valid && rd_oor) || (ccip.c1Tx_valid && wr_oor);
  assign len_err = (ccip.c0Tx_valid && (c0_req.cl_len != 2'b00)) ||
                   (ccip.c1Tx_valid && (c1_req.cl_len != 2'b00));

  always_comb begin
    c0_vld_d  = rq_pop;
    c0_hdr_d  = c0_hdr_q;
    c0_data_d = c0_data_q;
    // Memory is sampled before this edge's write, so a same-edge write is not seen.
    if (rq_pop) begin
      c0_hdr_d  = build_c0_rsp(rq_head.mdata);
      c0_data_d = mem[rq_head.addr[MEM_ADDR_WIDTH-1:0]];
    end
    c1_vld_d = wq_pop;
    c1_hdr_d = c1_hdr_q;
    if (wq_pop) c1_hdr_d = build_c1_rsp(wq_head.mdata);
    c0_af_d = (rq_cnt_d >= RQ_CW'(ALMFULL_THRESH));
    c1_af_d = (wq_cnt_d >= WQ_CW'(ALMFULL_THRESH));
    err_d   = err_q | {len_err, oor_err, ovf_err};
  end

  always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
    if (pck_cp2af_softReset) begin
      c0_vld_q  <= 1'b0;
      c0_hdr_q  <= '0;
      c0_data_q <= '0;
      c1_vld_q  <= 1'b0;
      c1_hdr_q  <= '0;
      c0_af_q   <= 1'b0;
      c1_af_q   <= 1'b0;
      err_q     <= '0;
    end else begin
      c0_vld_q  <= c0_vld_d;
      c0_hdr_q  <= c0_hdr_d;
      c0_data_q <= c0_data_d;
      c1_vld_q  <= c1_vld_d;
      c1_hdr_q  <= c1_hdr_d;
      c0_af_q   <= c0_af_d;
      c1_af_q   <= c1_af_d;
      err_q     <= err_d;
    end
  end

  assign ccip.c0Rx_rspValid    = c0_vld_q;
  assign ccip.c0Rx_hdr         = c0_hdr_q;
  assign ccip.c0Rx_data        = c0_data_q;
  assign ccip.c0Rx_mmioRdValid = 1'b0;
  assign ccip.c0Rx_mmioWrValid = 1'b0;
  assign ccip.c1Rx_rspValid    = c1_vld_q;
  assign ccip.c1Rx_hdr         = c1_hdr_q;
  assign ccip.c0TxAlmFull      = c0_af_q;
  assign ccip.c1TxAlmFull      = c1_af_q;
  assign err_status            = err_q;

  logic unused_hdr_bits;
  assign unused_hdr_bits = ^{c0_req.vc_sel, c0_req.rsvd1, c0_req.req_type, c0_req.rsvd0,
                             c1_req.rsvd2, c1_req.vc_sel, c1_req.sop, c1_req.rsvd1,
                             c1_req.req_type, c1_req.rsvd0,
                             rq_head.addr[CCIP_CLADDR_WIDTH-1:MEM_ADDR_WIDTH]};

endmodule

// File: tb/tb_ccip_host_mem_model.sv
// Directed bench for ccip_host_mem_model: drivers push expected responses, a negedge
// monitor pops and compares header, data and arrival cycle.
module tb_ccip_host_mem_model;
  import ccip_host_mem_model_pkg::*;

  localparam int LAT = 20;
  localparam int C0W = 32 + 28 + 512;
  localparam int C1W = 32 + 28;
  localparam logic [511:0] A5 = {64{8'hA5}};

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] err_status;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;

  logic [C0W-1:0] exp_c0_q[$];
  logic [C1W-1:0] exp_c1_q[$];
  logic [C0W-1:0] e0;
  logic [C1W-1:0] e1;

  ccip_host_mem_model_if ccip_if();

  ccip_host_mem_model #(
    .MEM_ADDR_WIDTH (10),
    .RD_LATENCY     (LAT),
    .RQ_DEPTH       (16),
    .WQ_DEPTH       (16),
    .ALMFULL_THRESH (12)
  ) dut (
    .pClk                (clk),
    .pck_cp2af_softReset (rst),
    .ccip                (ccip_if),
    .err_status          (err_status)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  // ---------------- helpers / drivers ----------------
  function automatic logic [511:0] pat(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {16{w}};
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [41:0] addr, input logic [15:0] mdata, input logic [1:0] cl_len,
                    input logic [511:0] data, input bit expect_rsp);
    ccip_if.c0Tx_hdr   = {2'b00, 2'b00, cl_len, 4'h0, 6'b0, addr, mdata};
    ccip_if.c0Tx_valid = 1'b1;
    if (expect_rsp) exp_c0_q.push_back({32'(cyc + 1 + LAT), 2'b01, 10'b0, mdata, data});
    @(negedge clk);
    ccip_if.c0Tx_valid = 1'b0;
  endtask

  task automatic wr(input logic [41:0] addr, input logic [15:0] mdata, input logic [1:0] cl_len,
                    input logic [511:0] data);
    ccip_if.c1Tx_hdr   = {6'b0, 2'b00, 1'b1, 1'b0, cl_len, 4'h0, 6'b0, addr, mdata};
    ccip_if.c1Tx_data  = data;
    ccip_if.c1Tx_valid = 1'b1;
    exp_c1_q.push_back({32'(cyc + 2), 12'b0, mdata});
    @(negedge clk);
    ccip_if.c1Tx_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_c0_q.size() != 0 || exp_c1_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_c0_q.size() != 0 || exp_c1_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: pending c0=%0d c1=%0d", exp_c0_q.size(), exp_c1_q.size());
      exp_c0_q.delete();
      exp_c1_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (ccip_if.c0Rx_rspValid) begin
      if (exp_c0_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL c0_unexpected: hdr %0h at cycle %0d, required no response", ccip_if.c0Rx_hdr, cyc);
      end else begin
        e0 = exp_c0_q.pop_front();
        check("c0_hdr",   512'(ccip_if.c0Rx_hdr), 512'(e0[539:512]));
        check("c0_data",  ccip_if.c0Rx_data, e0[511:0]);
        check("c0_cycle", 512'(cyc), 512'(e0[571:540]));
      end
    end
    if (ccip_if.c1Rx_rspValid) begin
      if (exp_c1_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL c1_unexpected: hdr %0h at cycle %0d, required no response", ccip_if.c1Rx_hdr, cyc);
      end else begin
        e1 = exp_c1_q.pop_front();
        check("c1_hdr",   512'(ccip_if.c1Rx_hdr), 512'(e1[27:0]));
        check("c1_cycle", 512'(cyc), 512'(e1[59:28]));
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int s;
    rst                = 1'b1;
    ccip_if.c0Tx_hdr   = '0;
    ccip_if.c0Tx_valid = 1'b0;
    ccip_if.c1Tx_hdr   = '0;
    ccip_if.c1Tx_data  = '0;
    ccip_if.c1Tx_valid = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_c0_valid", 512'(ccip_if.c0Rx_rspValid), 512'(0));
    check("rst_c1_valid", 512'(ccip_if.c1Rx_rspValid), 512'(0));
    check("rst_c0_af",    512'(ccip_if.c0TxAlmFull), 512'(0));
    check("rst_c1_af",    512'(ccip_if.c1TxAlmFull), 512'(0));
    check("rst_err",      512'(err_status), 512'(0));
    check("rst_c0_data",  ccip_if.c0Rx_data, 512'(0));
    check("rst_mmio_rd",  512'(ccip_if.c0Rx_mmioRdValid), 512'(0));
    check("rst_mmio_wr",  512'(ccip_if.c0Rx_mmioWrValid), 512'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // basic write then read-back
    wr(42'h5, 16'h11, 2'b00, A5);
    repeat (5) @(negedge clk);
    rd(42'h5, 16'h22, 2'b00, A5, 1'b1);
    drain(LAT + 10);

    // fill lines 0x20..0x2F with back-to-back writes
    for (int i = 0; i < 16; i++) wr(42'h20 + 42'(i), 16'h100 + 16'(i), 2'b00, pat(i));
    drain(40);

    // 16 back-to-back reads, AlmFull, then a 17th that overflows
    for (int i = 0; i < 16; i++) begin
      rd(42'h20 + 42'(i), 16'(i), 2'b00, pat(i), 1'b1);
      if (i == 10) check("af_after_11", 512'(ccip_if.c0TxAlmFull), 512'(0));
      if (i == 11) check("af_after_12", 512'(ccip_if.c0TxAlmFull), 512'(1));
    end
    rd(42'h20, 16'h99, 2'b00, '0, 1'b0);
    check("ovf_err",    512'(err_status), 512'(3'b001));
    check("af_when_full", 512'(ccip_if.c0TxAlmFull), 512'(1));
    drain(LAT + 40);
    repeat (5) @(negedge clk);
    check("af_drained", 512'(ccip_if.c0TxAlmFull), 512'(0));

    // read launching on the same edge as a write to its line sees old data
    wr(42'h30, 16'h200, 2'b00, pat(100));
    drain(10);
    s = cyc + 1;
    rd(42'h30, 16'h40, 2'b00, pat(100), 1'b1);
    while (cyc + 1 < s + LAT) @(negedge clk);
    wr(42'h30, 16'h41, 2'b00, pat(101));
    drain(LAT + 10);
    // write one edge earlier is visible
    s = cyc + 1;
    rd(42'h30, 16'h42, 2'b00, pat(102), 1'b1);
    while (cyc + 1 < s + LAT - 1) @(negedge clk);
    wr(42'h30, 16'h43, 2'b00, pat(102));
    drain(LAT + 10);

    // address wrap and cl_len error flags
    rd(42'h405, 16'h50, 2'b00, A5, 1'b1);
    drain(LAT + 10);
    check("oor_err", 512'(err_status), 512'(3'b011));
    wr(42'h6, 16'h51, 2'b01, pat(6));
    drain(10);
    check("len_err", 512'(err_status), 512'(3'b111));
    rd(42'h6, 16'h52, 2'b00, pat(6), 1'b1);
    drain(LAT + 10);

    // async reset with 4 reads still outstanding
    for (int i = 0; i < 5; i++) rd(42'h20 + 42'(i), 16'h60 + 16'(i), 2'b00, pat(i), 1'b1);
    n = 0;
    while (!ccip_if.c0Rx_rspValid && n < LAT + 10) begin
      @(negedge clk);
      n++;
    end
    check("rst_pre_rsp_seen", 512'(ccip_if.c0Rx_rspValid), 512'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_c0_valid", 512'(ccip_if.c0Rx_rspValid), 512'(0));
    check("arst_c0_data",  ccip_if.c0Rx_data, 512'(0));
    check("arst_c0_hdr",   512'(ccip_if.c0Rx_hdr), 512'(0));
    check("arst_err",      512'(err_status), 512'(0));
    check("arst_c0_af",    512'(ccip_if.c0TxAlmFull), 512'(0));
    exp_c0_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 10) @(negedge clk);
    check("post_rst_err", 512'(err_status), 512'(0));
    rd(42'h5, 16'h70, 2'b00, A5, 1'b1);
    drain(LAT + 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
